// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control core: owns the A, D and PC registers, decodes A/C-instructions,
// steers the external ALU and data memory, and resolves jumps.
module hack_cpu_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en_in,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [DATA_WIDTH-1:0] inM_in,
  output logic [DATA_WIDTH-1:0] aluX_out,
  output logic [DATA_WIDTH-1:0] aluY_out,
  output logic                  zx_out,
  output logic                  nx_out,
  output logic                  zy_out,
  output logic                  ny_out,
  output logic                  f_out,
  output logic                  no_out,
  input  logic [DATA_WIDTH-1:0] aluZ_in,
  input  logic                  zr_in,
  input  logic                  ng_in,
  output logic [DATA_WIDTH-1:0] outM_out,
  output logic                  writeM_out,
  output logic [ADDR_WIDTH-1:0] addressM_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_d;
  logic [ADDR_WIDTH-1:0] r_pc;

  logic w_is_c;
  logic w_jump;
  logic w_unused_bits;

  assign w_is_c        = instr_in[15];
  assign w_unused_bits = ^instr_in[14:13];

  assign w_jump = w_is_c & ((instr_in[2] & ng_in) |
                            (instr_in[1] & zr_in) |
                            (instr_in[0] & ~ng_in & ~zr_in));

  // The jump target is the A value from before this edge, even when d1 rewrites A.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_a  <= '0;
      r_d  <= '0;
      r_pc <= '0;
    end else if (en_in) begin
      if (!w_is_c) begin
        r_a <= instr_in;
      end else begin
        if (instr_in[5]) r_a <= aluZ_in;
        if (instr_in[4]) r_d <= aluZ_in;
      end
      r_pc <= w_jump ? r_a[ADDR_WIDTH-1:0] : r_pc + ADDR_WIDTH'(1);
    end
  end

  assign aluX_out = r_d;
  assign aluY_out = (w_is_c && instr_in[12]) ? inM_in : r_a;

  assign zx_out = w_is_c & instr_in[11];
  assign nx_out = w_is_c & instr_in[10];
  assign zy_out = w_is_c & instr_in[9];
  assign ny_out = w_is_c & instr_in[8];
  assign f_out  = w_is_c & instr_in[7];
  assign no_out = w_is_c & instr_in[6];

  assign outM_out     = aluZ_in;
  assign addressM_out = r_a[ADDR_WIDTH-1:0];
  assign pc_out       = r_pc;
  // Gating with the reset pin keeps stray memory writes out while reset is held.
  assign writeM_out   = w_is_c & instr_in[3] & en_in & rst_n_in;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: directed scenarios followed by random instruction streams,
// all compared against a plain-arithmetic model of the Hack register semantics.
module tb_hack_cpu_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        en_in;
  logic [15:0] instr_in;
  logic [15:0] inM_in;
  logic [15:0] aluX_out;
  logic [15:0] aluY_out;
  logic        zx_out, nx_out, zy_out, ny_out, f_out, no_out;
  logic [15:0] aluZ_in;
  logic        zr_in;
  logic        ng_in;
  logic [15:0] outM_out;
  logic        writeM_out;
  logic [14:0] addressM_out;
  logic [14:0] pc_out;

  int passed = 0;
  int total  = 0;

  int m_a, m_d, m_pc;
  int hold_a, hold_d, hold_pc;

  hack_cpu_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .instr_in(instr_in),
    .inM_in(inM_in), .aluX_out(aluX_out), .aluY_out(aluY_out),
    .zx_out(zx_out), .nx_out(nx_out), .zy_out(zy_out), .ny_out(ny_out),
    .f_out(f_out), .no_out(no_out), .aluZ_in(aluZ_in), .zr_in(zr_in), .ng_in(ng_in),
    .outM_out(outM_out), .writeM_out(writeM_out), .addressM_out(addressM_out),
    .pc_out(pc_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Expected combinational outputs, derived from the model state and current inputs.
  task automatic check_outputs();
    bit is_c;
    int ctrl;
    is_c = instr_in[15];
    ctrl = is_c ? int'((instr_in >> 6) & 16'h3F) : 0;
    chk("aluX", int'(aluX_out), m_d);
    chk("aluY", int'(aluY_out), (is_c && instr_in[12]) ? int'(inM_in) : m_a);
    chk("ctrl", int'({zx_out, nx_out, zy_out, ny_out, f_out, no_out}), ctrl);
    chk("outM", int'(outM_out), int'(aluZ_in));
    chk("writeM", int'(writeM_out), int'(is_c && instr_in[3] && en_in && rst_n_in));
    chk("addressM", int'(addressM_out), m_a % 32768);
    chk("pc", int'(pc_out), m_pc);
  endtask

  task automatic model_edge();
    bit is_c, take;
    int old_a;
    if (!en_in) return;
    is_c  = instr_in[15];
    old_a = m_a;
    take  = is_c && ((instr_in[2] && ng_in) || (instr_in[1] && zr_in) ||
                     (instr_in[0] && !ng_in && !zr_in));
    if (!is_c) m_a = int'(instr_in);
    else begin
      if (instr_in[5]) m_a = int'(aluZ_in);
      if (instr_in[4]) m_d = int'(aluZ_in);
    end
    m_pc = take ? old_a % 32768 : (m_pc + 1) % 32768;
  endtask

  // Called just after a rising edge: drive, settle, check, clock, update model.
  task automatic step(input logic [15:0] ins, input logic [15:0] z, input logic [15:0] m,
                      input logic zr, input logic ng, input logic en);
    instr_in = ins; aluZ_in = z; inM_in = m; zr_in = zr; ng_in = ng; en_in = en;
    #2;
    check_outputs();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  initial begin
    m_a = 0; m_d = 0; m_pc = 0;
    rst_n_in = 1'b0; en_in = 1'b1; instr_in = 16'hE008; inM_in = 16'h0;
    aluZ_in = 16'hBEEF; zr_in = 1'b0; ng_in = 1'b0;
    #12;
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_addr", int'(addressM_out), 0);
    chk("rst_aluX", int'(aluX_out), 0);
    chk("rst_writeM", int'(writeM_out), 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    // A-instruction
    step(16'h0015, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("ainst_addr", int'(addressM_out), 16'h0015);
    chk("ainst_pc", int'(pc_out), 1);
    chk("ainst_writeM", int'(writeM_out), 0);

    // D=A then M=D
    step(16'hEC10, 16'h0015, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("dwrite_aluX", int'(aluX_out), 16'h0015);
    instr_in = 16'hE308; aluZ_in = 16'h0015; #1;
    chk("mwrite_writeM", int'(writeM_out), 1);
    chk("mwrite_outM", int'(outM_out), 16'h0015);
    step(16'hE308, 16'h0015, 16'h0, 1'b0, 1'b0, 1'b1);

    // Unconditional jump, then a JGT that is not taken
    step(16'h0100, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'hEA87, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("jmp_pc", int'(pc_out), 16'h0100);
    step(16'h0100, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'hE301, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    chk("jgt_not_taken_pc", int'(pc_out), 16'h0102);

    // A rewritten and jump taken on the same edge
    step(16'h0200, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'hEC27, 16'h0300, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("simul_pc", int'(pc_out), 16'h0200);
    chk("simul_addr", int'(addressM_out), 16'h0300);

    // PC wrap
    step(16'h7FFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'hEA87, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("pre_wrap_pc", int'(pc_out), 16'h7FFF);
    step(16'h0000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("wrap_pc", int'(pc_out), 0);

    // Hold with en_in=0
    step(16'h0123, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'hEC10, 16'h4321, 16'h0, 1'b0, 1'b0, 1'b1);
    hold_a = m_a; hold_d = m_d; hold_pc = m_pc;
    for (int i = 0; i < 3; i++) begin
      step(16'hE008, 16'hAAAA, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("hold_pc", int'(pc_out), hold_pc);
      chk("hold_a", int'(addressM_out), hold_a);
      chk("hold_d", int'(aluX_out), hold_d);
    end

    // Asynchronous reset mid-cycle with PC=0x0042
    step(16'hEC10, 16'h5555, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'h0042, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'hEA87, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("pre_reset_pc", int'(pc_out), 16'h0042);
    instr_in = 16'hE308; #2;
    rst_n_in = 1'b0; #1;
    m_a = 0; m_d = 0; m_pc = 0;
    chk("async_rst_pc", int'(pc_out), 0);
    chk("async_rst_addr", int'(addressM_out), 0);
    chk("async_rst_aluX", int'(aluX_out), 0);
    chk("async_rst_writeM", int'(writeM_out), 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    step(16'h0007, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("restart_pc", int'(pc_out), 1);

    // Random instruction streams
    for (int i = 0; i < 300; i++) begin
      step(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 7) != 0));
    end
    check_outputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
